// File: rtl/scan_button_if.sv
// Signal bundle between the slot select generator and scan_button_reader.
// Handshake: no valid/ready; sel_idx and sense are levels sampled every clock, and btn_press, btn_release, scan_error are single-cycle strobes.
interface scan_button_if #(
    parameter int NUM_SLOTS = 5
);
    logic [2:0]           sel_idx;
    logic                 sense;
    logic [NUM_SLOTS-1:0] btn_state;
    logic [NUM_SLOTS-1:0] btn_press;
    logic [NUM_SLOTS-1:0] btn_release;
    logic                 scan_error;
    logic                 scan_stall;

    modport master (
        output sel_idx,
        output sense,
        input  btn_state,
        input  btn_press,
        input  btn_release,
        input  scan_error,
        input  scan_stall
    );

    modport slave (
        input  sel_idx,
        input  sense,
        output btn_state,
        output btn_press,
        output btn_release,
        output scan_error,
        output scan_stall
    );
endinterface

// File: rtl/scan_button_reader.sv
// Scanned button reader: settle after each index change, take one sample, debounce each slot with a saturating integrator.
// Define SCAN_WATCHDOG_EN to build the stall watchdog that flags a frozen sel_idx.
module scan_button_reader #(
    parameter int NUM_SLOTS     = 5,
    parameter int SETTLE_CYCLES = 1000,
    parameter int DEB_MAX       = 3,
    parameter int WDOG_CYCLES   = 4000000
) (
    input  logic          clk,
    input  logic          reset_n,
    scan_button_if.slave  bus,
    output logic [1:0]    dbg_state
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IW = $clog2(DEB_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] INTEG_MAX   = IW'(DEB_MAX);
    localparam logic [3:0]    SLOTS_W     = 4'(NUM_SLOTS);

    if (NUM_SLOTS < 1 || NUM_SLOTS > 8 || SETTLE_CYCLES < 1 || DEB_MAX < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("scan_button_reader: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [2:0]                    prev_idx;
    logic [2:0]                    cur_idx;
    logic                          change;
    logic                          sample_en;
    logic                          sample_go;
    logic                          sense_meta;
    logic                          sense_sync;
    logic [NUM_SLOTS-1:0][IW-1:0]  integ;
    logic [NUM_SLOTS-1:0]          btn_state_r;
    logic [NUM_SLOTS-1:0]          btn_prev_r;
    logic [NUM_SLOTS-1:0]          press_r;
    logic [NUM_SLOTS-1:0]          release_r;
    logic                          err_r;
    logic                          wdog_clear;
    logic                          sample_block;

    assign change    = (bus.sel_idx != prev_idx);
    assign sample_go = sample_en & ~sample_block;
    assign dbg_state = state_q;

    // sense is asynchronous to clk; only sense_sync is ever used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sense_meta <= 1'b0;
            sense_sync <= 1'b0;
        end else begin
            sense_meta <= bus.sense;
            sense_sync <= sense_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_idx <= 3'd0;
            cur_idx  <= 3'd0;
            err_r    <= 1'b0;
        end else begin
            prev_idx <= bus.sel_idx;
            err_r    <= change && ({1'b0, bus.sel_idx} >= SLOTS_W);
            if (change) begin
                cur_idx <= bus.sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A change overrides every state, but a SAMPLE cycle still commits its sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_en = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end
            end
            ST_SAMPLE: begin
                sample_en = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_HOLD;
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
        if (change) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
        end
    end

    // Invalid indices match no slot, so their samples fall on the floor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            integ <= '0;
        end else if (wdog_clear) begin
            integ <= '0;
        end else if (sample_go) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cur_idx == 3'(i)) begin
                    if (sense_sync) begin
                        if (integ[i] != INTEG_MAX) integ[i] <= integ[i] + 1'b1;
                    end else begin
                        if (integ[i] != '0) integ[i] <= integ[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_state_r <= '0;
            btn_prev_r  <= '0;
            press_r     <= '0;
            release_r   <= '0;
        end else if (wdog_clear) begin
            btn_state_r <= '0;
            btn_prev_r  <= '0;
            press_r     <= '0;
            release_r   <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (integ[i] == INTEG_MAX) begin
                    btn_state_r[i] <= 1'b1;
                end else if (integ[i] == '0) begin
                    btn_state_r[i] <= 1'b0;
                end
            end
            btn_prev_r <= btn_state_r;
            press_r    <= btn_state_r & ~btn_prev_r;
            release_r  <= ~btn_state_r & btn_prev_r;
        end
    end

`ifdef SCAN_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

    logic [WW-1:0] stall_cnt;
    logic          stall_r;
    logic          stall_hit;

    // Clearing is repeated every stalled cycle, which also keeps pulses silent.
    assign stall_hit    = (stall_cnt == WDOG_MAX) && !change;
    assign wdog_clear   = stall_hit;
    assign sample_block = stall_r | stall_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            stall_r   <= 1'b0;
        end else if (change) begin
            stall_cnt <= '0;
            stall_r   <= 1'b0;
        end else begin
            if (stall_cnt != WDOG_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (stall_hit) stall_r <= 1'b1;
        end
    end

    assign bus.scan_stall = stall_r;
`else
    assign wdog_clear     = 1'b0;
    assign sample_block   = 1'b0;
    assign bus.scan_stall = 1'b0;
`endif

    assign bus.btn_state   = btn_state_r;
    assign bus.btn_press   = press_r;
    assign bus.btn_release = release_r;
    assign bus.scan_error  = err_r;

endmodule

// File: tb/tb_scan_button_reader.sv
// Bench for scan_button_reader: directed scan rounds plus random scanning against a cycle-history model.
module tb_scan_button_reader;

    localparam int NS   = 5;
    localparam int S    = 4;
    localparam int DM   = 3;
    localparam int WD   = 100;
    localparam int MAXC = 20000;

    // clock / reset
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    scan_button_if #(.NUM_SLOTS(NS)) bus ();

    scan_button_reader #(
        .NUM_SLOTS(NS),
        .SETTLE_CYCLES(S),
        .DEB_MAX(DM),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // model history, indexed by cycle number since reset release
    logic [2:0]    sel_h   [MAXC];
    logic          sense_h [MAXC];
    logic          chg_h   [MAXC];
    logic [NS-1:0] ms      [MAXC];
    int            n;
    int            last_c;
    logic [2:0]    cur_m;
    int            integ_m [NS];
    logic [NS-1:0] st_m;
    bit            mon_en = 1'b0;
    bit            pressed [8];

    int compared   = 0;
    int mismatched = 0;
    int press_cnt, release_cnt, err_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at t=%0t cycle %0d: got %0h expected %0h", name, $time, n, act, exp);
        end
    endtask

    function automatic logic [NS-1:0] ms_at(input int k);
        return (k >= 0) ? ms[k] : '0;
    endfunction

    // scoreboard: sample happens S+1 cycles after the last change; outputs are delayed views of the model state
    always @(negedge clk) begin
        if (mon_en && n < MAXC) begin
            logic          chg;
            logic          sv;
            logic          exp_err;
            logic [NS-1:0] exp_st, exp_pr, exp_rl;
            sel_h[n]   = bus.sel_idx;
            sense_h[n] = bus.sense;
            chg        = (sel_h[n] != ((n > 0) ? sel_h[n-1] : 3'd0));
            chg_h[n]   = chg;
            if (last_c == n - S - 1 && cur_m < NS) begin
                sv = (n >= 2) ? sense_h[n-2] : 1'b0;
                if (sv) integ_m[cur_m] = (integ_m[cur_m] < DM) ? integ_m[cur_m] + 1 : DM;
                else    integ_m[cur_m] = (integ_m[cur_m] > 0) ? integ_m[cur_m] - 1 : 0;
                if (integ_m[cur_m] == DM)     st_m[cur_m] = 1'b1;
                else if (integ_m[cur_m] == 0) st_m[cur_m] = 1'b0;
            end
            if (chg) begin
                last_c = n;
                cur_m  = sel_h[n];
            end
            ms[n]   = st_m;
            exp_st  = ms_at(n - 2);
            exp_pr  = ms_at(n - 3) & ~ms_at(n - 4);
            exp_rl  = ~ms_at(n - 3) & ms_at(n - 4);
            exp_err = (n >= 1) && chg_h[n-1] && (sel_h[n-1] >= NS);
            check("btn_state",   32'(bus.btn_state),   32'(exp_st));
            check("btn_press",   32'(bus.btn_press),   32'(exp_pr));
            check("btn_release", 32'(bus.btn_release), 32'(exp_rl));
            check("scan_error",  32'(bus.scan_error),  32'(exp_err));
            check("scan_stall",  32'(bus.scan_stall),  32'd0);
            if (bus.btn_press == 5'b00100)   press_cnt++;
            if (bus.btn_release == 5'b00100) release_cnt++;
            if (bus.scan_error)              err_cnt++;
            n++;
        end
    end

    // driver tasks
    task automatic do_reset();
        mon_en = 1'b0;
        #($urandom_range(1, 8));
        reset_n     = 1'b0;
        bus.sel_idx = 3'd0;
        bus.sense   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        last_c = -1;
        cur_m = 3'd0;
        st_m = '0;
        for (int i = 0; i < NS; i++) integ_m[i] = 0;
        press_cnt = 0;
        release_cnt = 0;
        err_cnt = 0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic step(input logic [2:0] idx, input logic s, input int hold);
        bus.sel_idx = idx;
        bus.sense   = s;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic round(input logic s2);
        for (int i = 0; i < NS; i++) step(3'(i), (i == 2) ? s2 : 1'b0, 8);
    endtask

    task automatic check_now(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        @(negedge clk);
        case (act_sel)
            32'd0:   check(name, 32'(bus.btn_state), exp);
            32'd1:   check(name, 32'(bus.scan_stall), exp);
            default: check(name, 32'(bus.btn_release), exp);
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.sel_idx = 3'd0;
        bus.sense   = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        @(negedge clk);
        check("reset_state",   32'(bus.btn_state),   32'd0);
        check("reset_press",   32'(bus.btn_press),   32'd0);
        check("reset_release", 32'(bus.btn_release), 32'd0);
        check("reset_error",   32'(bus.scan_error),  32'd0);
        @(posedge clk);
        #1;

        round(1'b0);
        check_now("idle_round", 0, 32'd0);
        round(1'b1);
        round(1'b1);
        round(1'b1);
        check_now("pressed_after_3", 0, 32'h04);
        round(1'b0);
        round(1'b1);
        round(1'b0);
        check_now("hysteresis_hold", 0, 32'h04);
        round(1'b0);
        round(1'b0);
        check_now("released", 0, 32'd0);
        check("press_pulse_count",   32'(press_cnt),   32'd1);
        check("release_pulse_count", 32'(release_cnt), 32'd1);

        for (int r = 0; r < 3; r++) begin
            step(3'd2, 1'b1, 2);
            step(3'd1, 1'b0, 8);
        end
        check_now("abandoned_settle", 0, 32'd0);

        step(3'd6, 1'b1, 8);
        step(3'd0, 1'b0, 8);
        check_now("invalid_state", 0, 32'd0);
        check("scan_error_count", 32'(err_cnt), 32'd1);

        // random scanning, entered through an asynchronous mid-run reset
        step(3'd3, 1'b1, 3);
        do_reset();
        for (int i = 0; i < 8; i++) pressed[i] = 1'b0;
        for (int k = 0; k < 300; k++) begin
            logic [2:0] idx;
            logic       s;
            idx = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, NS - 1)) : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) pressed[idx] = ~pressed[idx];
            s = pressed[idx] ^ ($urandom_range(0, 9) == 0);
            step(idx, s, $urandom_range(1, 10));
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end

`ifdef SCAN_WATCHDOG_EN
        begin
            int rel_seen;
            do_reset();
            mon_en = 1'b0;
            for (int r = 0; r < 3; r++) begin
                step(3'd0, 1'b1, 8);
                step(3'd1, 1'b0, 8);
            end
            check_now("wdog_pre_state", 0, 32'h01);
            rel_seen = 0;
            repeat (120) begin
                @(negedge clk);
                if (bus.btn_release != '0) rel_seen++;
            end
            check("wdog_stall_set",   32'(bus.scan_stall), 32'd1);
            check("wdog_state_clear", 32'(bus.btn_state),  32'd0);
            check("wdog_no_release",  32'(rel_seen),       32'd0);
            @(posedge clk);
            #1;
            step(3'd2, 1'b0, 3);
            check_now("wdog_stall_clear", 1, 32'd0);
        end
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
